// File: rtl/demixer_iq_if.sv
// Sample-in / IQ-out bundle of the fs/4 quadrature downconverter.
// Latency: n/a (signal bundle only).
// Backpressure: none; the source paces samples with din_valid and the sink takes every dout_valid pulse.
interface demixer_iq_if;
    logic signed [14:0] din;
    logic               din_valid;
    logic               phase_clr;
    logic signed [14:0] i_out;
    logic signed [14:0] q_out;
    logic               dout_valid;
    logic        [1:0]  lo_phase;

    // Sample source / result consumer side.
    modport master (
        output din, din_valid, phase_clr,
        input  i_out, q_out, dout_valid, lo_phase
    );

    // Downconverter side.
    modport slave (
        input  din, din_valid, phase_clr,
        output i_out, q_out, dout_valid, lo_phase
    );
endinterface

// File: rtl/demixer_iq.sv
// fs/4 complex downconverter (x * e^(-j*pi*n/2)) with integrate-and-dump decimation by 2^DECIM_LOG2.
// Latency: i_out/q_out/dout_valid are registered on the edge that accepts the last sample of a block.
// Backpressure: none; din_valid gaps of any length simply stall the LO, counter and accumulators.
module demixer_iq #(
    parameter int DECIM_LOG2 = 4
) (
    input  logic         clock,
    input  logic         reset,
    demixer_iq_if.slave  bus
);
    // Accumulator holds 2^(DECIM_LOG2-1) terms of magnitude <= 2^14 per channel, plus sign.
    localparam int AW = 15 + DECIM_LOG2;
    localparam int SH = DECIM_LOG2 - 1;

    // Block length must be a multiple of the 4-phase LO and the accumulator must stay modest.
    if (DECIM_LOG2 < 2 || DECIM_LOG2 > 8) begin : g_param_check
        $error("demixer_iq: DECIM_LOG2 must be within 2..8");
    end

    logic        [1:0]            phase;
    logic        [DECIM_LOG2-1:0] cnt;
    logic signed [AW-1:0]         acc_i;
    logic signed [AW-1:0]         acc_q;
    logic signed [14:0]           i_out_r;
    logic signed [14:0]           q_out_r;
    logic                         dout_valid_r;

    logic                         accept;
    logic                         last;
    logic                         negate;
    logic                         to_q;
    logic signed [15:0]           x_pos;
    logic signed [15:0]           x_neg;
    logic signed [AW-1:0]         term;
    logic signed [AW-1:0]         acc_i_nxt;
    logic signed [AW-1:0]         acc_q_nxt;
    logic signed [14:0]           res_i;
    logic signed [14:0]           res_q;

    // LO rotation: phases 0/2 feed I, 1/3 feed Q; phases 1/2 subtract. Extending to
    // 16 bits before negating keeps -(-16384) exact.
    always_comb begin
        accept    = bus.din_valid && !bus.phase_clr;
        last      = accept && (cnt == {DECIM_LOG2{1'b1}});
        negate    = phase[0] ^ phase[1];
        to_q      = phase[0];
        x_pos     = {bus.din[14], bus.din};
        x_neg     = -x_pos;
        term      = AW'(negate ? x_neg : x_pos);
        acc_i_nxt = (accept && !to_q) ? acc_i + term : acc_i;
        acc_q_nxt = (accept &&  to_q) ? acc_q + term : acc_q;
        // Floor divide by the number of nonzero terms; the result always fits 15 bits.
        res_i     = 15'(acc_i_nxt >>> SH);
        res_q     = 15'(acc_q_nxt >>> SH);
    end

    // LO phase, sample counter, accumulators and registered block results.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase        <= 2'd0;
            cnt          <= '0;
            acc_i        <= '0;
            acc_q        <= '0;
            i_out_r      <= '0;
            q_out_r      <= '0;
            dout_valid_r <= 1'b0;
        end else if (bus.phase_clr) begin
            // Partial block is dropped; results from the previous block stay visible.
            phase        <= 2'd0;
            cnt          <= '0;
            acc_i        <= '0;
            acc_q        <= '0;
            dout_valid_r <= 1'b0;
        end else begin
            dout_valid_r <= last;
            if (accept) begin
                phase <= phase + 2'd1;
                cnt   <= cnt + 1'b1;
                if (last) begin
                    // Last sample is folded in on the same edge that dumps the block.
                    i_out_r <= res_i;
                    q_out_r <= res_q;
                    acc_i   <= '0;
                    acc_q   <= '0;
                end else begin
                    acc_i <= acc_i_nxt;
                    acc_q <= acc_q_nxt;
                end
            end
        end
    end

    assign bus.i_out      = i_out_r;
    assign bus.q_out      = q_out_r;
    assign bus.dout_valid = dout_valid_r;
    assign bus.lo_phase   = phase;
endmodule

// File: tb/tb_demixer_iq.sv
// Directed bench for demixer_iq (DECIM_LOG2=4) with a queue-based scoreboard.
// Inputs change on the falling edge; the monitor samples 1 time unit after each rising edge.
// Expected I/Q per block are hand-computed constants pushed when the block's last sample is issued.
module tb_demixer_iq;
    logic clock;
    logic reset;

    demixer_iq_if bus();

    demixer_iq #(.DECIM_LOG2(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Scoreboard of expected {i, q} per block.
    int exp_i_q[$];
    int exp_q_q[$];

    // Reference state updated by the stimulus before each rising edge.
    int exp_cnt   = 0;  // accepted samples in current block after the coming edge
    bit exp_pulse = 0;  // coming edge must raise dout_valid
    bit exp_rst   = 1;  // coming edge is a reset edge
    int hold_i    = 0;
    int hold_q    = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus; the reference counter follows the documented priority.
    task automatic drive(input bit r, input bit c, input bit v, input int x);
        @(negedge clock);
        reset         = r;
        bus.phase_clr = c;
        bus.din_valid = v;
        bus.din       = 15'(x);
        exp_rst       = r;
        exp_pulse     = 1'b0;
        if (r || c) begin
            exp_cnt = 0;
        end else if (v) begin
            exp_pulse = (exp_cnt == 15);
            exp_cnt   = (exp_cnt + 1) % 16;
        end
    endtask

    // Sixteen accepted samples of a 4-sample repeating pattern, optionally with idle gaps.
    task automatic run_block(input int a, input int b, input int c, input int d,
                             input int ei, input int eq, input bit gaps);
        int pat[4];
        pat[0] = a; pat[1] = b; pat[2] = c; pat[3] = d;
        for (int n = 0; n < 16; n++) begin
            if (gaps) begin
                while ($urandom_range(0, 1) == 1)
                    drive(1'b0, 1'b0, 1'b0, 12345);
            end
            if (n == 15) begin
                exp_i_q.push_back(ei);
                exp_q_q.push_back(eq);
            end
            drive(1'b0, 1'b0, 1'b1, pat[n % 4]);
        end
    endtask

    // Monitor: pops on every DUT pulse, otherwise checks that outputs hold.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            check("dout_valid", int'(bus.dout_valid), int'(exp_pulse));
            check("lo_phase", int'(bus.lo_phase), exp_cnt % 4);
            if (bus.dout_valid) begin
                check("pulse_on_valid_cycle", int'(bus.din_valid && !bus.phase_clr), 1);
                if (exp_i_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: i=%0d q=%0d with empty scoreboard at %0t",
                             bus.i_out, bus.q_out, $time);
                end else begin
                    hold_i = exp_i_q.pop_front();
                    hold_q = exp_q_q.pop_front();
                    check("i_out", int'(bus.i_out), hold_i);
                    check("q_out", int'(bus.q_out), hold_q);
                end
            end else begin
                if (exp_rst) begin
                    hold_i = 0;
                    hold_q = 0;
                end
                check("i_out_hold", int'(bus.i_out), hold_i);
                check("q_out_hold", int'(bus.q_out), hold_q);
            end
        end
    end

    initial begin
        reset         = 1'b1;
        bus.phase_clr = 1'b0;
        bus.din_valid = 1'b0;
        bus.din       = '0;
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 1'b1, 777);
        drive(1'b0, 1'b0, 1'b0, 0);

        // DC input cancels in both channels.
        run_block(1000, 1000, 1000, 1000, 0, 0, 1'b0);
        // In-phase tone, two blocks.
        run_block(1000, 0, -1000, 0, 1000, 0, 1'b0);
        run_block(1000, 0, -1000, 0, 1000, 0, 1'b0);
        // Quadrature tones of both signs.
        run_block(0, 1000, 0, -1000, 0, -1000, 1'b0);
        run_block(0, -1000, 0, 1000, 0, 1000, 1'b0);
        // Full-scale extremes, floor rounding on the negative side.
        run_block(16383, 0, -16384, 0, 16383, 0, 1'b0);
        run_block(-16384, 0, 16383, 0, -16384, 0, 1'b0);
        // Random idle gaps must not change the result or pulse timing.
        run_block(1000, 0, -1000, 0, 1000, 0, 1'b1);
        run_block(1000, 0, -1000, 0, 1000, 0, 1'b1);
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b0, 5000);

        // phase_clr mid-block: partial block dropped, clear-cycle sample ignored.
        for (int k = 0; k < 7; k++) drive(1'b0, 1'b0, 1'b1, 5000);
        drive(1'b0, 1'b1, 1'b1, 9000);
        run_block(1000, 0, -1000, 0, 1000, 0, 1'b0);

        // Same with reset: outputs read 0 until the next block completes.
        for (int k = 0; k < 7; k++) drive(1'b0, 1'b0, 1'b1, 5000);
        drive(1'b1, 1'b0, 1'b1, 9000);
        run_block(1000, 0, -1000, 0, 1000, 0, 1'b0);

        for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, 1'b0, 0);
        @(posedge clock);
        #2;
        check("scoreboard_drained", exp_i_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
